// File: rtl/id_stage_decoder.sv
// id_stage_decoder: registered RV32I instruction-decode stage (ID/EX register).
// Takes a fetched instruction over a valid/ready handshake. It decodes the
// control flags and the sign-extended immediate, then holds the result in the
// ID/EX output register.
// It detects load-use hazards against its own output register and inserts
// bubbles. A flush from branch resolution kills both the input and the
// output register.
// Optional feature: define RV_MEXT_EN to decode the M extension
// (funct7 = 7'h01 on OP). When it is undefined, that encoding is illegal.
module id_stage_decoder #(
    parameter int XLEN = 32,
    parameter int ALUW = 5,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] imm,
    output logic [REGW-1:0] rs1,
    output logic [REGW-1:0] rs2,
    output logic [REGW-1:0] rd,
    output logic [ALUW-1:0] ALU_ctrl,
    output logic            ALU_src,
    output logic            MEM_wen,
    output logic            MEM_ren,
    output logic            WB_sel,
    output logic            Reg_WB,
    output logic            branch,
    output logic            jump,
    output logic            auipc,
    output logic [2:0]      mem_size,
    output logic            illegal,
    output logic            load_stall
);

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU operation codes
    localparam logic [ALUW-1:0] ALU_ADD   = ALUW'(5'h00);
    localparam logic [ALUW-1:0] ALU_SUB   = ALUW'(5'h01);
    localparam logic [ALUW-1:0] ALU_XOR   = ALUW'(5'h02);
    localparam logic [ALUW-1:0] ALU_OR    = ALUW'(5'h03);
    localparam logic [ALUW-1:0] ALU_AND   = ALUW'(5'h04);
    localparam logic [ALUW-1:0] ALU_SLL   = ALUW'(5'h05);
    localparam logic [ALUW-1:0] ALU_SRL   = ALUW'(5'h06);
    localparam logic [ALUW-1:0] ALU_BEQ   = ALUW'(5'h07);
    localparam logic [ALUW-1:0] ALU_BNE   = ALUW'(5'h08);
    localparam logic [ALUW-1:0] ALU_SLT   = ALUW'(5'h09);
    localparam logic [ALUW-1:0] ALU_SRA   = ALUW'(5'h0A);
    localparam logic [ALUW-1:0] ALU_AUIPC = ALUW'(5'h0B);
    localparam logic [ALUW-1:0] ALU_SLTU  = ALUW'(5'h0C);
    localparam logic [ALUW-1:0] ALU_LUI   = ALUW'(5'h0D);
    localparam logic [ALUW-1:0] ALU_BLT   = ALUW'(5'h0E);
    localparam logic [ALUW-1:0] ALU_BGE   = ALUW'(5'h0F);
    localparam logic [ALUW-1:0] ALU_BLTU  = ALUW'(5'h10);
    localparam logic [ALUW-1:0] ALU_BGEU  = ALUW'(5'h11);
    localparam logic [ALUW-1:0] ALU_LINK  = ALUW'(5'h12);
`ifdef RV_MEXT_EN
    localparam logic [ALUW-1:0] ALU_MUL    = ALUW'(5'h13);
    localparam logic [ALUW-1:0] ALU_MULH   = ALUW'(5'h14);
    localparam logic [ALUW-1:0] ALU_MULHSU = ALUW'(5'h15);
    localparam logic [ALUW-1:0] ALU_MULHU  = ALUW'(5'h16);
    localparam logic [ALUW-1:0] ALU_DIV    = ALUW'(5'h17);
    localparam logic [ALUW-1:0] ALU_DIVU   = ALUW'(5'h18);
    localparam logic [ALUW-1:0] ALU_REM    = ALUW'(5'h19);
    localparam logic [ALUW-1:0] ALU_REMU   = ALUW'(5'h1A);
`endif

    // Contents of the ID/EX register
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [ALUW-1:0] alu;
        logic            alu_src;
        logic            mem_wen;
        logic            mem_ren;
        logic            wb_sel;
        logic            reg_wb;
        logic            branch;
        logic            jump;
        logic            auipc;
        logic [2:0]      mem_size;
        logic            illegal;
    } id_ex_t;

    id_ex_t r_q;
    id_ex_t w_d;

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [REGW-1:0] w_rs1;
    logic [REGW-1:0] w_rs2;
    logic [REGW-1:0] w_rd;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_rs1    = REGW'(instr[19:15]);
    assign w_rs2    = REGW'(instr[24:20]);
    assign w_rd     = REGW'(instr[11:7]);

    // Sign-extended immediates, one per format
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_imm_i = XLEN'($signed(instr[31:20]));
    assign w_imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign w_imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({instr[31:12], 12'h000}));
    assign w_imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    // Shift-immediate upper bits must be zero, apart from the arithmetic
    // select bit instr[30]. On RV64, shamt also uses instr[25].
    logic w_sll_ok;
    logic w_sr_ok;

    assign w_sll_ok = (XLEN == 64) ? (instr[31:26] == 6'b000000)
                                   : (instr[31:25] == 7'b0000000);
    assign w_sr_ok  = (XLEN == 64) ? ({instr[31], instr[29:26]} == 5'b00000)
                                   : ({instr[31], instr[29:25]} == 6'b000000);

    // Raw decode results, before the illegal-instruction gating
    logic [ALUW-1:0] w_alu;
    logic [XLEN-1:0] w_imm;
    logic            w_alu_src;
    logic            w_mem_wen;
    logic            w_mem_ren;
    logic            w_wb_sel;
    logic            w_reg_wb;
    logic            w_branch;
    logic            w_jump;
    logic            w_auipc;
    logic            w_ill;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_is_mem;

    // Decode the opcode/funct fields into control flags and the immediate
    always_comb begin
        w_alu     = ALU_ADD;
        w_imm     = {XLEN{1'b0}};
        w_alu_src = 1'b0;
        w_mem_wen = 1'b0;
        w_mem_ren = 1'b0;
        w_wb_sel  = 1'b0;
        w_reg_wb  = 1'b0;
        w_branch  = 1'b0;
        w_jump    = 1'b0;
        w_auipc   = 1'b0;
        w_ill     = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_is_mem  = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_alu     = ALU_LUI;
                w_alu_src = 1'b1;
                w_reg_wb  = 1'b1;
                w_imm     = w_imm_u;
            end
            OP_AUIPC: begin
                w_alu     = ALU_AUIPC;
                w_alu_src = 1'b1;
                w_reg_wb  = 1'b1;
                w_auipc   = 1'b1;
                w_imm     = w_imm_u;
            end
            OP_JAL: begin
                w_alu    = ALU_LINK;
                w_reg_wb = 1'b1;
                w_jump   = 1'b1;
                w_imm    = w_imm_j;
            end
            OP_JALR: begin
                // Target is rs1 + imm, computed with ADD
                w_alu     = ALU_ADD;
                w_alu_src = 1'b1;
                w_reg_wb  = 1'b1;
                w_jump    = 1'b1;
                w_imm     = w_imm_i;
                w_use_rs1 = 1'b1;
                w_ill     = (w_funct3 != 3'b000);
            end
            OP_BRANCH: begin
                w_branch  = 1'b1;
                w_imm     = w_imm_b;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                case (w_funct3)
                    3'b000:  w_alu = ALU_BEQ;
                    3'b001:  w_alu = ALU_BNE;
                    3'b100:  w_alu = ALU_BLT;
                    3'b101:  w_alu = ALU_BGE;
                    3'b110:  w_alu = ALU_BLTU;
                    3'b111:  w_alu = ALU_BGEU;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_alu_src = 1'b1;
                w_mem_ren = 1'b1;
                w_wb_sel  = 1'b1;
                w_reg_wb  = 1'b1;
                w_imm     = w_imm_i;
                w_use_rs1 = 1'b1;
                w_is_mem  = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ill = 1'b0;
                    default:                                w_ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_alu_src = 1'b1;
                w_mem_wen = 1'b1;
                w_imm     = w_imm_s;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_is_mem  = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010: w_ill = 1'b0;
                    default:                w_ill = 1'b1;
                endcase
            end
            OP_IMM: begin
                w_alu_src = 1'b1;
                w_reg_wb  = 1'b1;
                w_imm     = w_imm_i;
                w_use_rs1 = 1'b1;
                case (w_funct3)
                    3'b000: w_alu = ALU_ADD;
                    3'b010: w_alu = ALU_SLT;
                    3'b011: w_alu = ALU_SLTU;
                    3'b100: w_alu = ALU_XOR;
                    3'b110: w_alu = ALU_OR;
                    3'b111: w_alu = ALU_AND;
                    3'b001: begin
                        w_alu = ALU_SLL;
                        w_ill = ~w_sll_ok;
                    end
                    3'b101: begin
                        w_alu = instr[30] ? ALU_SRA : ALU_SRL;
                        w_ill = ~w_sr_ok;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_REG: begin
                w_reg_wb  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                case (w_funct7)
                    7'h00: begin
                        case (w_funct3)
                            3'b000:  w_alu = ALU_ADD;
                            3'b001:  w_alu = ALU_SLL;
                            3'b010:  w_alu = ALU_SLT;
                            3'b011:  w_alu = ALU_SLTU;
                            3'b100:  w_alu = ALU_XOR;
                            3'b101:  w_alu = ALU_SRL;
                            3'b110:  w_alu = ALU_OR;
                            3'b111:  w_alu = ALU_AND;
                            default: w_ill = 1'b1;
                        endcase
                    end
                    7'h20: begin
                        case (w_funct3)
                            3'b000:  w_alu = ALU_SUB;
                            3'b101:  w_alu = ALU_SRA;
                            default: w_ill = 1'b1;
                        endcase
                    end
`ifdef RV_MEXT_EN
                    7'h01: begin
                        case (w_funct3)
                            3'b000:  w_alu = ALU_MUL;
                            3'b001:  w_alu = ALU_MULH;
                            3'b010:  w_alu = ALU_MULHSU;
                            3'b011:  w_alu = ALU_MULHU;
                            3'b100:  w_alu = ALU_DIV;
                            3'b101:  w_alu = ALU_DIVU;
                            3'b110:  w_alu = ALU_REM;
                            3'b111:  w_alu = ALU_REMU;
                            default: w_ill = 1'b1;
                        endcase
                    end
`endif
                    default: w_ill = 1'b1;
                endcase
            end
            OP_FENCE: begin
                // Memory ordering is trivially satisfied in-order; pass as a no-op
                w_ill = 1'b0;
            end
            OP_SYSTEM: begin
                // Only ECALL and EBREAK are part of the base set
                w_ill = ~((instr == 32'h0000_0073) || (instr == 32'h0010_0073));
            end
            default: w_ill = 1'b1;
        endcase
    end

    // An illegal instruction must not write state or redirect the PC
    logic w_reg_wb_g;
    assign w_reg_wb_g = w_reg_wb & ~w_ill;

    assign w_d.valid    = 1'b1;
    assign w_d.pc       = pc_in;
    assign w_d.imm      = w_imm;
    assign w_d.rs1      = w_rs1;
    assign w_d.rs2      = w_rs2;
    assign w_d.rd       = w_reg_wb_g ? w_rd : {REGW{1'b0}};
    assign w_d.alu      = w_alu;
    assign w_d.alu_src  = w_alu_src;
    assign w_d.mem_wen  = w_mem_wen & ~w_ill;
    assign w_d.mem_ren  = w_mem_ren & ~w_ill;
    assign w_d.wb_sel   = w_wb_sel;
    assign w_d.reg_wb   = w_reg_wb_g;
    assign w_d.branch   = w_branch & ~w_ill;
    assign w_d.jump     = w_jump & ~w_ill;
    assign w_d.auipc    = w_auipc;
    assign w_d.mem_size = w_is_mem ? w_funct3 : 3'b000;
    assign w_d.illegal  = w_ill;

    // Load-use hazard: the load still in ID/EX targets a register the incoming
    // instruction reads. Only loads with a real destination can conflict.
    logic w_haz_rs1;
    logic w_haz_rs2;
    logic w_adv;

    assign w_haz_rs1  = w_use_rs1 & (w_rs1 == r_q.rd);
    assign w_haz_rs2  = w_use_rs2 & (w_rs2 == r_q.rd);
    assign load_stall = r_q.valid & r_q.mem_ren & (r_q.rd != {REGW{1'b0}}) & in_valid
                      & (w_haz_rs1 | w_haz_rs2);

    // The register may take a new value when it is empty or EX is draining it
    assign w_adv    = ~r_q.valid | out_ready;
    assign in_ready = ~reset & w_adv & ~load_stall & ~flush;

    // ID/EX register: reset, flush, hazard bubble, load decoded fields, or hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (flush) begin
            r_q <= '0;
        end else if (w_adv) begin
            if (load_stall || !in_valid) begin
                r_q <= '0;
            end else begin
                r_q <= w_d;
            end
        end else begin
            r_q <= r_q;
        end
    end

    assign out_valid = r_q.valid;
    assign pc_out    = r_q.pc;
    assign imm       = r_q.imm;
    assign rs1       = r_q.rs1;
    assign rs2       = r_q.rs2;
    assign rd        = r_q.rd;
    assign ALU_ctrl  = r_q.alu;
    assign ALU_src   = r_q.alu_src;
    assign MEM_wen   = r_q.mem_wen;
    assign MEM_ren   = r_q.mem_ren;
    assign WB_sel    = r_q.wb_sel;
    assign Reg_WB    = r_q.reg_wb;
    assign branch    = r_q.branch;
    assign jump      = r_q.jump;
    assign auipc     = r_q.auipc;
    assign mem_size  = r_q.mem_size;
    assign illegal   = r_q.illegal;

endmodule

// File: tb/tb_id_stage_decoder.sv
// tb_id_stage_decoder: table-driven bench for id_stage_decoder, plus
// hand-written sequences for reset, load-use, flush and back-pressure.
module tb_id_stage_decoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  ALU_ctrl;
    logic        ALU_src;
    logic        MEM_wen;
    logic        MEM_ren;
    logic        WB_sel;
    logic        Reg_WB;
    logic        branch;
    logic        jump;
    logic        auipc;
    logic [2:0]  mem_size;
    logic        illegal;
    logic        load_stall;

    id_stage_decoder #(.XLEN(32), .ALUW(5), .REGW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .pc_out(pc_out), .imm(imm), .rs1(rs1), .rs2(rs2),
        .rd(rd), .ALU_ctrl(ALU_ctrl), .ALU_src(ALU_src), .MEM_wen(MEM_wen),
        .MEM_ren(MEM_ren), .WB_sel(WB_sel), .Reg_WB(Reg_WB), .branch(branch),
        .jump(jump), .auipc(auipc), .mem_size(mem_size), .illegal(illegal),
        .load_stall(load_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag bits: {ALU_src, MEM_wen, MEM_ren, WB_sel, Reg_WB, branch, jump, auipc, illegal}
    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        chk_rs;
        logic [4:0]  rd;
        logic [4:0]  alu;
        logic [8:0]  flags;
        logic [2:0]  msz;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] I_ADDI = 32'hFFD0_0293;
    localparam logic [31:0] I_ADD  = 32'h0023_03B3;
    localparam logic [31:0] I_SUB  = 32'h4020_8433;
    localparam logic [31:0] I_SLTU = 32'h0020_B533;
    localparam logic [31:0] I_LW   = 32'h0000_A303;
    localparam logic [31:0] I_BLT  = 32'hFE20_CCE3;

    function automatic logic [8:0] dut_flags();
        return {ALU_src, MEM_wen, MEM_ren, WB_sel, Reg_WB, branch, jump, auipc, illegal};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [31:0] ins, input logic [31:0] im,
                       input logic [4:0] r1, input logic [4:0] r2, input logic c,
                       input logic [4:0] d, input logic [4:0] a, input logic [8:0] f,
                       input logic [2:0] m);
        vec_t v;
        v.name = nm; v.ins = ins; v.imm = im; v.rs1 = r1; v.rs2 = r2; v.chk_rs = c;
        v.rd = d; v.alu = a; v.flags = f; v.msz = m;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name    instr         imm           rs1    rs2    chk   rd     alu    flags   msz
        add("addi",  I_ADDI,       32'hFFFFFFFD, 5'd0,  5'd29, 1'b1, 5'd5,  5'h00, 9'h110, 3'd0);
        add("add",   I_ADD,        32'h00000000, 5'd6,  5'd2,  1'b1, 5'd7,  5'h00, 9'h010, 3'd0);
        add("sub",   I_SUB,        32'h00000000, 5'd1,  5'd2,  1'b1, 5'd8,  5'h01, 9'h010, 3'd0);
        add("sra",   32'h4041D4B3, 32'h00000000, 5'd3,  5'd4,  1'b1, 5'd9,  5'h0A, 9'h010, 3'd0);
        add("sltu",  I_SLTU,       32'h00000000, 5'd1,  5'd2,  1'b1, 5'd10, 5'h0C, 9'h010, 3'd0);
        add("srai",  32'h40365593, 32'h00000403, 5'd12, 5'd3,  1'b1, 5'd11, 5'h0A, 9'h110, 3'd0);
        add("srli",  32'h00365593, 32'h00000003, 5'd12, 5'd3,  1'b1, 5'd11, 5'h06, 9'h110, 3'd0);
        add("lw",    I_LW,         32'h00000000, 5'd1,  5'd0,  1'b1, 5'd6,  5'h00, 9'h170, 3'd2);
        add("sw",    32'hFE512E23, 32'hFFFFFFFC, 5'd2,  5'd5,  1'b1, 5'd0,  5'h00, 9'h180, 3'd2);
        add("blt",   I_BLT,        32'hFFFFFFF8, 5'd1,  5'd2,  1'b1, 5'd0,  5'h0E, 9'h008, 3'd0);
        add("lui",   32'h123456B7, 32'h12345000, 5'd0,  5'd0,  1'b0, 5'd13, 5'h0D, 9'h110, 3'd0);
        add("auipc", 32'h80000717, 32'h80000000, 5'd0,  5'd0,  1'b0, 5'd14, 5'h0B, 9'h112, 3'd0);
        add("jal",   32'h010000EF, 32'h00000010, 5'd0,  5'd0,  1'b0, 5'd1,  5'h12, 9'h014, 3'd0);
        add("jalr",  32'h00008067, 32'h00000000, 5'd1,  5'd0,  1'b1, 5'd0,  5'h00, 9'h114, 3'd0);
`ifdef RV_MEXT_EN
        add("mul",   32'h02208033, 32'h00000000, 5'd1,  5'd2,  1'b1, 5'd0,  5'h13, 9'h010, 3'd0);
`else
        add("mul",   32'h02208033, 32'h00000000, 5'd1,  5'd2,  1'b1, 5'd0,  5'h00, 9'h001, 3'd0);
`endif
        add("badop", 32'hFFFFFFFF, 32'h00000000, 5'd0,  5'd0,  1'b0, 5'd0,  5'h00, 9'h001, 3'd0);
        add("badf7", 32'h202303B3, 32'h00000000, 5'd6,  5'd2,  1'b1, 5'd0,  5'h00, 9'h001, 3'd0);
        add("lbu",   32'h7FF1C783, 32'h000007FF, 5'd3,  5'd31, 1'b1, 5'd15, 5'h00, 9'h170, 3'd4);

        // Reset held two cycles with an instruction offered
        reset = 1'b1; in_valid = 1'b1; instr = I_ADDI; pc_in = 32'h0;
        flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst.out_valid", out_valid, 1'b0);
            chk("rst.in_ready", in_ready, 1'b0);
            chk("rst.flags", dut_flags(), 9'h000);
            chk("rst.imm", imm, 32'h0);
            chk("rst.alu", ALU_ctrl, 5'h00);
            chk("rst.rd", rd, 5'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst.in_ready", in_ready, 1'b1);

        // Back-to-back decode table, one instruction per cycle
        for (int i = 0; i < vq.size(); i++) begin
            instr = vq[i].ins;
            pc_in = 32'h1000 + 32'(i * 4);
            in_valid = 1'b1;
            tick();
            chk({vq[i].name, ".valid"}, out_valid, 1'b1);
            chk({vq[i].name, ".pc"}, pc_out, 32'h1000 + 32'(i * 4));
            chk({vq[i].name, ".imm"}, imm, vq[i].imm);
            chk({vq[i].name, ".rd"}, rd, vq[i].rd);
            chk({vq[i].name, ".alu"}, ALU_ctrl, vq[i].alu);
            chk({vq[i].name, ".flags"}, dut_flags(), vq[i].flags);
            chk({vq[i].name, ".msz"}, mem_size, vq[i].msz);
            if (vq[i].chk_rs) begin
                chk({vq[i].name, ".rs1"}, rs1, vq[i].rs1);
                chk({vq[i].name, ".rs2"}, rs2, vq[i].rs2);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("idle.bubble", out_valid, 1'b0);

        // Load-use: LW x6 then ADD x7,x6,x2 costs exactly one bubble
        instr = I_LW; in_valid = 1'b1;
        tick();
        chk("lu.lw_valid", out_valid, 1'b1);
        chk("lu.lw_ren", MEM_ren, 1'b1);
        instr = I_ADD;
        #1;
        chk("lu.stall", load_stall, 1'b1);
        chk("lu.in_ready", in_ready, 1'b0);
        tick();
        chk("lu.bubble", out_valid, 1'b0);
        chk("lu.stall_gone", load_stall, 1'b0);
        chk("lu.ready_back", in_ready, 1'b1);
        tick();
        chk("lu.add_valid", out_valid, 1'b1);
        chk("lu.add_rs1", rs1, 5'd6);
        chk("lu.add_rd", rd, 5'd7);

        // BLT then flush: output killed, offered instruction not accepted
        instr = I_BLT;
        tick();
        chk("fl.branch", branch, 1'b1);
        chk("fl.alu", ALU_ctrl, 5'h0E);
        instr = I_ADDI; flush = 1'b1;
        #1;
        chk("fl.in_ready", in_ready, 1'b0);
        tick();
        chk("fl.out_valid", out_valid, 1'b0);
        chk("fl.branch_clr", branch, 1'b0);
        chk("fl.regwb_clr", Reg_WB, 1'b0);
        flush = 1'b0;

        // Back-pressure: SUB held three cycles while SLTU waits
        instr = I_SUB;
        tick();
        chk("bp.sub_valid", out_valid, 1'b1);
        out_ready = 1'b0; instr = I_SLTU;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp.in_ready", in_ready, 1'b0);
            tick();
            chk("bp.hold_valid", out_valid, 1'b1);
            chk("bp.hold_alu", ALU_ctrl, 5'h01);
            chk("bp.hold_rd", rd, 5'd8);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", in_ready, 1'b1);
        tick();
        chk("bp.sltu_alu", ALU_ctrl, 5'h0C);
        chk("bp.sltu_rd", rd, 5'd10);

        // Flush overrides a stalled output register
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("bp.stalled_valid", out_valid, 1'b1);
        flush = 1'b1;
        tick();
        chk("bp.flush_stalled", out_valid, 1'b0);
        flush = 1'b0; out_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
